// File: rtl/bus_transfer_sequencer.sv
// Moves one word per command into the register bank, either register to register or from an immediate.
// Strobes are decoded from the current state and the latched selects only, never from live inputs.
module bus_transfer_sequencer #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_REGS  = 4,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          load_imm,
    input  logic [SEL_W-1:0]              src_sel,
    input  logic [SEL_W-1:0]              dst_sel,
    input  logic [WORD_SIZE-1:0]          imm_value,
    input  logic [NUM_REGS*WORD_SIZE-1:0] reg_data,
    output logic [NUM_REGS-1:0]           reg_enable,
    output logic [NUM_REGS-1:0]           reg_read,
    output logic [NUM_REGS-1:0]           reg_write,
    output logic [WORD_SIZE-1:0]          bus_value,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    // state   | meaning
    // IDLE    | waiting for start
    // READ    | source register drives its output_value
    // CAPTURE | source data sampled into hold
    // WRITE   | destination loads hold from the bus
    // DONE    | one-cycle completion, error valid
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

    state_t               state;
    state_t               state_nx;
    logic [SEL_W-1:0]     src_q;
    logic [SEL_W-1:0]     dst_q;
    logic                 err_q;
    logic [WORD_SIZE-1:0] hold;
    logic [WORD_SIZE-1:0] captured;
    logic                 cmd_bad;

    // The source index only matters for register moves.
    assign cmd_bad = (int'(dst_sel) >= NUM_REGS) || (!load_imm && (int'(src_sel) >= NUM_REGS));

    always_comb begin
        captured = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src_q == SEL_W'(i)) captured = reg_data[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            err_q <= 1'b0;
            hold  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                src_q <= src_sel;
                dst_q <= dst_sel;
                err_q <= cmd_bad;
                if (!cmd_bad && load_imm) hold <= imm_value;
            end
            if (state == CAPTURE) hold <= captured;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cmd_bad)       state_nx = DONE;
                    else if (load_imm) state_nx = WRITE;
                    else               state_nx = READ;
                end
            end
            READ:    state_nx = CAPTURE;
            CAPTURE: state_nx = WRITE;
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        reg_read  = '0;
        reg_write = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_read[i]  = (state == READ)  && (src_q == SEL_W'(i));
            reg_write[i] = (state == WRITE) && (dst_q == SEL_W'(i));
        end
    end

    assign reg_enable = reg_read | reg_write;
    // hold only changes on a fresh capture or immediate, so the bus keeps its last value.
    assign bus_value  = hold;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign error      = (state == DONE) && err_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench: a 4-register instance with a small register bank model, plus a 3-register
// instance for out-of-range selects.
module tb_bus_transfer_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       start3 = 1'b0;
    logic       load_imm = 1'b0;
    logic [1:0] src_sel = '0;
    logic [1:0] dst_sel = '0;
    logic [7:0] imm_value = '0;

    logic [31:0] reg_data;
    logic [3:0]  reg_enable, reg_read, reg_write;
    logic [7:0]  bus_value;
    logic        busy, done, error;

    logic [23:0] reg_data3 = 24'h332211;
    logic [2:0]  reg_enable3, reg_read3, reg_write3;
    logic [7:0]  bus_value3;
    logic        busy3, done3, error3;

    logic [7:0] regs [4];
    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    bus_transfer_sequencer #(.WORD_SIZE(8), .NUM_REGS(4)) u_dut (
        .clock(clock), .reset(reset), .start(start), .load_imm(load_imm),
        .src_sel(src_sel), .dst_sel(dst_sel), .imm_value(imm_value), .reg_data(reg_data),
        .reg_enable(reg_enable), .reg_read(reg_read), .reg_write(reg_write),
        .bus_value(bus_value), .busy(busy), .done(done), .error(error)
    );

    bus_transfer_sequencer #(.WORD_SIZE(8), .NUM_REGS(3)) u_dut3 (
        .clock(clock), .reset(reset), .start(start3), .load_imm(load_imm),
        .src_sel(src_sel), .dst_sel(dst_sel), .imm_value(imm_value), .reg_data(reg_data3),
        .reg_enable(reg_enable3), .reg_read(reg_read3), .reg_write(reg_write3),
        .bus_value(bus_value3), .busy(busy3), .done(done3), .error(error3)
    );

    // Register bank model: loads the bus on enable&write, presets while reset is low.
    always @(posedge clock) begin
        if (!reset) begin
            regs[0] <= 8'h7E;
            regs[1] <= 8'h3C;
            regs[2] <= 8'h00;
            regs[3] <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++)
                if (reg_enable[i] && reg_write[i]) regs[i] <= bus_value;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) reg_data[i*8 +: 8] = regs[i];
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_enable", 32'(reg_enable), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done_error", 32'({done, error}), 32'h0);
        chk("rst_bus", 32'(bus_value), 32'h0);
        reset = 1'b1;
        cyc();

        // Reset asserted in the middle of READ
        start = 1'b1; load_imm = 1'b0; src_sel = 2'd1; dst_sel = 2'd3;
        cyc();
        chk("t1_read", 32'(reg_read), 32'h2);
        start = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t1_strobes_drop", 32'({reg_enable, reg_read, reg_write}), 32'h0);
        chk("t1_busy_done", 32'({busy, done}), 32'h0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("t1_idle_busy", 32'(busy), 32'h0);
        cyc();
        chk("t1_no_done", 32'({done, reg_write}), 32'h0);
        chk("t1_reg3_untouched", 32'(regs[3]), 32'h0);

        // Immediate move A5 -> reg2
        start = 1'b1; load_imm = 1'b1; dst_sel = 2'd2; imm_value = 8'hA5;
        cyc();
        start = 1'b0; imm_value = 8'h00;
        chk("t2_write", 32'(reg_write), 32'h4);
        chk("t2_enable", 32'(reg_enable), 32'h4);
        chk("t2_read", 32'(reg_read), 32'h0);
        chk("t2_bus", 32'(bus_value), 32'hA5);
        chk("t2_busy_done", 32'({busy, done}), 32'h2);
        cyc();
        chk("t2_done_error", 32'({done, error}), 32'h2);
        chk("t2_reg2", 32'(regs[2]), 32'hA5);
        cyc();
        chk("t2_idle", 32'({busy, done}), 32'h0);

        // Register move reg1 (3C) -> reg3, inputs changed mid-flight
        start = 1'b1; load_imm = 1'b0; src_sel = 2'd1; dst_sel = 2'd3; imm_value = 8'hFF;
        cyc();
        chk("t3_read", 32'({reg_enable, reg_read, reg_write}), 32'h220);
        start = 1'b0; src_sel = 2'd2; dst_sel = 2'd0;
        cyc();
        chk("t3_capture_quiet", 32'(reg_enable), 32'h0);
        cyc();
        chk("t3_write", 32'({reg_enable, reg_read, reg_write}), 32'h808);
        chk("t3_bus", 32'(bus_value), 32'h3C);
        cyc();
        chk("t3_done_error", 32'({done, error}), 32'h2);
        chk("t3_reg3", 32'(regs[3]), 32'h3C);
        cyc();

        // Start while busy is ignored; reg2 (A5) -> reg1
        start = 1'b1; load_imm = 1'b0; src_sel = 2'd2; dst_sel = 2'd1;
        cyc();
        start = 1'b0;
        cyc();
        start = 1'b1; load_imm = 1'b1; dst_sel = 2'd0; imm_value = 8'h11;
        cyc();
        start = 1'b0;
        chk("t4_write", 32'(reg_write), 32'h2);
        chk("t4_bus", 32'(bus_value), 32'hA5);
        cyc();
        chk("t4_done", 32'(done), 32'h1);
        cyc();
        chk("t4_not_queued", 32'({busy, done, reg_enable}), 32'h0);
        chk("t4_reg0_kept", 32'(regs[0]), 32'h7E);
        chk("t4_reg1", 32'(regs[1]), 32'hA5);
        start = 1'b1; load_imm = 1'b1; dst_sel = 2'd3; imm_value = 8'h5A;
        cyc();
        start = 1'b0;
        chk("t4_next_write", 32'(reg_write), 32'h8);
        chk("t4_next_bus", 32'(bus_value), 32'h5A);
        cyc();
        chk("t4_next_done", 32'(done), 32'h1);
        cyc();

        // Self move reg0 (7E)
        start = 1'b1; load_imm = 1'b0; src_sel = 2'd0; dst_sel = 2'd0;
        cyc();
        start = 1'b0;
        chk("t6_read", 32'({reg_read, reg_write}), 32'h10);
        cyc(); cyc();
        chk("t6_write", 32'({reg_read, reg_write}), 32'h01);
        chk("t6_bus", 32'(bus_value), 32'h7E);
        cyc();
        chk("t6_done", 32'({done, error}), 32'h2);
        chk("t6_reg0", 32'(regs[0]), 32'h7E);
        cyc();

        // Out-of-range selects on the 3-register instance
        start3 = 1'b1; load_imm = 1'b0; src_sel = 2'd0; dst_sel = 2'd3;
        cyc();
        start3 = 1'b0;
        chk("t5_dst_err", 32'({busy3, done3, error3}), 32'h7);
        chk("t5_no_strobes", 32'({reg_enable3, reg_read3, reg_write3}), 32'h0);
        chk("t5_hold_kept", 32'(bus_value3), 32'h0);
        cyc();
        chk("t5_idle", 32'({busy3, done3}), 32'h0);
        start3 = 1'b1; load_imm = 1'b0; src_sel = 2'd3; dst_sel = 2'd0; imm_value = 8'h99;
        cyc();
        start3 = 1'b0;
        chk("t5_src_err", 32'({done3, error3, reg_enable3}), 32'h18);
        chk("t5_src_err_hold", 32'(bus_value3), 32'h0);
        cyc();
        start3 = 1'b1; load_imm = 1'b1; src_sel = 2'd3; dst_sel = 2'd1; imm_value = 8'h42;
        cyc();
        start3 = 1'b0;
        chk("t5_imm_src_ignored", 32'({reg_write3, bus_value3}), 32'h242);
        cyc();
        chk("t5_imm_done", 32'({done3, error3}), 32'h2);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
